frame_writer: RTL and testbench
===============================

Name: frame_writer

Overview:
- GPU-side pixel engine that writes the double-buffered frame store. It drives the pixel write port (x, y, data, write enable) and the buffer select line that the display path consumes.
- Accepts fill, clear and swap commands over a valid/ready handshake and rasterises rectangles at one pixel per clock.
- Performs buffer swaps only at the start of VGA vertical sync, so a frame is never displayed half-written.

Parameters:
- H_RES, 320, horizontal pixels per frame.
- V_RES, 240, vertical lines per frame.
- SYNC_STAGES, 2, flip-flop stages used to synchronise vga_vs into the GPU clock domain (minimum 2).

Ports:
- gpu_clk_150  input  1  GPU clock; the only clock in the block.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 = fill rectangle, 01 = clear frame, 10 = swap buffers, 11 = no-op.
- cmd_x0, cmd_y0  input  10 each  rectangle top-left corner, inclusive.
- cmd_x1, cmd_y1  input  10 each  rectangle bottom-right corner, inclusive.
- cmd_color  input  4  pixel value written by fill and clear.
- vga_vs  input  1  VGA vertical sync, active-low, asynchronous to gpu_clk_150.
- gpu_x, gpu_y  output  10 each  write coordinates.
- gpu_data  output  4  write pixel value.
- gpu_we  output  1  write strobe; one pixel is written per cycle while high.
- buffer_select  output  1  0 = writes go to buffer 0 and buffer 1 is displayed; 1 = the opposite.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_ready = 1, gpu_we = 0, gpu_x = 0, gpu_y = 0, gpu_data = 0, buffer_select = 0, busy = 0, state = IDLE, all synchroniser flops = 1.
- Handshake:
  - A command is accepted on any rising edge where cmd_valid and cmd_ready are both high.
  - cmd_ready equals (state == IDLE).
  - Operands are latched at acceptance; inputs are ignored at all other times.
- States: IDLE, FILL, WAIT_VS.
- IDLE, on command acceptance:
  - fill → clip, then go to FILL. If the clipped rectangle is empty, stay in IDLE and perform no writes.
  - clear → behaves as fill with (0, 0)..(H_RES-1, V_RES-1).
  - swap → WAIT_VS.
  - no-op → stay in IDLE; cmd_ready stays 1.
- Clipping (at acceptance):
  - x1c = min(x1, H_RES-1) and y1c = min(y1, V_RES-1).
  - The rectangle is empty if x0 > x1c or y0 > y1c; this includes x0 ≥ H_RES or y0 ≥ V_RES.
  - Comparisons are unsigned 10-bit.
- FILL:
  - The first write occurs in the cycle after acceptance: gpu_we = 1, gpu_x = x0, gpu_y = y0, gpu_data = colour.
  - Each subsequent cycle advances x by one. When x == x1c, x wraps to x0 and y increments.
  - The write at (x1c, y1c) is the last one; the following cycle has gpu_we = 0 and the state returns to IDLE.
  - Total writes = (x1c-x0+1)*(y1c-y0+1), one per cycle, with no bubbles.
  - After the last write, gpu_x and gpu_y hold their final values.
- Output timing: gpu_x, gpu_y, gpu_data and gpu_we are registered outputs with no combinational path from any input.
- Vsync detection:
  - vga_vs passes through SYNC_STAGES flops, followed by one edge-detect register.
  - vs_fall is high for one cycle when the synchronised value transitions 1→0.
- WAIT_VS:
  - gpu_we = 0.
  - On the cycle vs_fall is high, buffer_select toggles (registered) and the state returns to IDLE; cmd_ready = 1 on the next cycle.
  - A vs_fall observed in any other state is ignored.
  - A vs_fall in the same cycle that a swap is accepted does not count; the block waits for the next falling edge.
- buffer_select changes only on a swap completion or on reset.
- Reset asserted mid-operation: all state clears immediately (asynchronously), any fill in progress is abandoned, and buffer_select returns to 0.
- Latency:
  - fill: accept→first write = 1 cycle; accept→cmd_ready high = N+1 cycles for N pixels.
  - swap: 1 to 2 cycles after a synchronised vsync falling edge, plus up to one frame of waiting for that edge.

Test Plan:
- Fill (10,20)-(11,21) colour 5 → writes on 4 consecutive cycles at (10,20), (11,20), (10,21), (11,21), each with data 5; cmd_ready returns high on cycle 5 after acceptance.
- Clear colour 0xA → 76800 consecutive writes from (0,0) to (319,239) in raster order; no other coordinates appear.
- Fill (318,238)-(400,300) → clipped to 2×2: writes at (318,238), (319,238), (318,239), (319,239). Fill (5,5)-(4,9) → zero writes and cmd_ready stays high.
- Swap issued with vga_vs high → buffer_select stays 0 and cmd_ready stays 0; drive vga_vs low → buffer_select becomes 1 within SYNC_STAGES+2 cycles, then cmd_ready goes high. A second swap returns buffer_select to 0.
- Back-to-back commands: a fill of 3 pixels followed immediately by a second fill of 2 pixels (cmd_valid held high) → 3 writes, one idle accept cycle, then 2 writes; no write is dropped or duplicated.
- Assert reset during pixel 100 of a clear → gpu_we goes to 0 immediately, buffer_select goes to 0, cmd_ready goes to 1 after release; a new fill executes normally.

Source files
------------

// File: rtl/frame_writer.sv
// Double-buffered frame store writer: rasterises fill/clear rectangles at one pixel per clock and swaps buffers on the vsync falling edge.
// First write lands 1 cycle after accept; cmd_ready is low whenever the engine is not IDLE.
module frame_writer #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic       gpu_clk_150,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [3:0] cmd_color,
    input  logic       vga_vs,
    output logic [9:0] gpu_x,
    output logic [9:0] gpu_y,
    output logic [3:0] gpu_data,
    output logic       gpu_we,
    output logic       buffer_select,
    output logic       busy
);

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [9:0] X_MAX    = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_WAIT_VS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [9:0]             x_q, x_d;
    logic [9:0]             y_q, y_d;
    logic [3:0]             data_q, data_d;
    logic                   we_q, we_d;
    logic [9:0]             x0_q, x0_d;
    logic [9:0]             x1c_q, x1c_d;
    logic [9:0]             y1c_q, y1c_d;
    logic                   bs_q, bs_d;
    logic [SYNC_STAGES-1:0] vs_sync_q;
    logic                   vs_prev_q;
    logic                   vs_fall;

    logic [9:0] rx0, ry0, rx1, ry1, cx1, cy1;
    logic       rect_empty;

    // vga_vs idles high, so the synchroniser resets to 1 to avoid a false edge after reset.
    always_ff @(posedge gpu_clk_150 or negedge reset) begin
        if (!reset) begin
            vs_sync_q <= '1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vga_vs};
            vs_prev_q <= vs_sync_q[SYNC_STAGES-1];
        end
    end

    assign vs_fall = vs_prev_q & ~vs_sync_q[SYNC_STAGES-1];

    // Clear is simply a fill of the whole frame; clipping applies to both.
    always_comb begin
        rx0 = cmd_x0;
        ry0 = cmd_y0;
        rx1 = cmd_x1;
        ry1 = cmd_y1;
        if (cmd_op == OP_CLEAR) begin
            rx0 = '0;
            ry0 = '0;
            rx1 = X_MAX;
            ry1 = Y_MAX;
        end
        cx1        = (rx1 > X_MAX) ? X_MAX : rx1;
        cy1        = (ry1 > Y_MAX) ? Y_MAX : ry1;
        rect_empty = (rx0 > cx1) || (ry0 > cy1);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        we_d    = 1'b0;
        x0_d    = x0_q;
        x1c_d   = x1c_q;
        y1c_d   = y1c_q;
        bs_d    = bs_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_op == OP_FILL || cmd_op == OP_CLEAR) && !rect_empty) begin
                        state_d = S_FILL;
                        x_d     = rx0;
                        y_d     = ry0;
                        data_d  = cmd_color;
                        we_d    = 1'b1;
                        x0_d    = rx0;
                        x1c_d   = cx1;
                        y1c_d   = cy1;
                    end else if (cmd_op == OP_SWAP) begin
                        state_d = S_WAIT_VS;
                    end
                end
            end
            S_FILL: begin
                // Outputs currently show a write; decide whether another follows.
                if (x_q == x1c_q && y_q == y1c_q) begin
                    state_d = S_IDLE;
                end else begin
                    we_d = 1'b1;
                    if (x_q == x1c_q) begin
                        x_d = x0_q;
                        y_d = y_q + 10'd1;
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            S_WAIT_VS: begin
                if (vs_fall) begin
                    bs_d    = ~bs_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk_150 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            x0_q    <= '0;
            x1c_q   <= '0;
            y1c_q   <= '0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            we_q    <= we_d;
            x0_q    <= x0_d;
            x1c_q   <= x1c_d;
            y1c_q   <= y1c_d;
            bs_q    <= bs_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign gpu_x         = x_q;
    assign gpu_y         = y_q;
    assign gpu_data      = data_q;
    assign gpu_we        = we_q;
    assign buffer_select = bs_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: table vectors, randomized fills against a raster model, and hand-written swap/back-to-back/reset sequences.
module tb_frame_writer;

    localparam int H  = 320;
    localparam int V  = 240;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [3:0] cmd_color;
    logic       vga_vs;
    logic [9:0] gpu_x, gpu_y;
    logic [3:0] gpu_data;
    logic       gpu_we;
    logic       buffer_select;
    logic       busy;

    frame_writer #(.H_RES(H), .V_RES(V), .SYNC_STAGES(SS)) dut (
        .gpu_clk_150  (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x0       (cmd_x0),
        .cmd_y0       (cmd_y0),
        .cmd_x1       (cmd_x1),
        .cmd_y1       (cmd_y1),
        .cmd_color    (cmd_color),
        .vga_vs       (vga_vs),
        .gpu_x        (gpu_x),
        .gpu_y        (gpu_y),
        .gpu_data     (gpu_data),
        .gpu_we       (gpu_we),
        .buffer_select(buffer_select),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] d;
    } wr_t;

    typedef struct {
        logic [1:0] op;
        int x0, y0, x1, y1, c;
        int n;
        int fx, fy, lx, ly;
    } vec_t;

    wr_t wr_q[$];
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always @(negedge clk) begin
        if (gpu_we) wr_q.push_back({gpu_x, gpu_y, gpu_data});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: every pixel of the clipped rectangle, in raster order.
    task automatic model_cmd(input logic [1:0] op, input int x0, input int y0,
                             input int x1, input int y1, input int c);
        wr_t e;
        if (op == 2'b01) begin
            x0 = 0; y0 = 0; x1 = H - 1; y1 = V - 1;
        end else if (op != 2'b00) begin
            return;
        end
        if (x1 > H - 1) x1 = H - 1;
        if (y1 > V - 1) y1 = V - 1;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                e.x = 10'(x); e.y = 10'(y); e.d = 4'(c);
                exp_q.push_back(e);
            end
    endtask

    task automatic cmp_q(input string name);
        int bad = -1;
        checks++;
        if (wr_q.size() != exp_q.size()) bad = 0;
        else
            for (int i = 0; i < wr_q.size(); i++)
                if (bad < 0 && wr_q[i] !== exp_q[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            if (wr_q.size() != exp_q.size())
                $display("FAIL %s: got %0d writes, expected %0d", name, wr_q.size(), exp_q.size());
            else
                $display("FAIL %s: write %0d got (%0d,%0d,%0h), expected (%0d,%0d,%0h)", name, bad,
                         wr_q[bad].x, wr_q[bad].y, wr_q[bad].d, exp_q[bad].x, exp_q[bad].y, exp_q[bad].d);
        end
    endtask

    task automatic drive(input logic [1:0] op, input int x0, input int y0,
                         input int x1, input int y1, input int c);
        cmd_op = op; cmd_x0 = 10'(x0); cmd_y0 = 10'(y0);
        cmd_x1 = 10'(x1); cmd_y1 = 10'(y1); cmd_color = 4'(c);
        cmd_valid = 1'b1;
    endtask

    // Issues one command and returns cycles from acceptance until cmd_ready is seen high.
    task automatic run_cmd(input logic [1:0] op, input int x0, input int y0,
                           input int x1, input int y1, input int c, output int lat);
        wr_q.delete(); exp_q.delete();
        model_cmd(op, x0, y0, x1, y1, c);
        @(negedge clk);
        drive(op, x0, y0, x1, y1, c);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!cmd_ready && lat < 80000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_swap(input logic exp_bs);
        int n;
        @(negedge clk);
        drive(2'b10, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("swap_hold_bs", int'(buffer_select), int'(!exp_bs));
        chk("swap_hold_ready", int'(cmd_ready), 0);
        chk("swap_hold_busy", int'(busy), 1);
        vga_vs = 1'b0;
        n = 0;
        while (buffer_select !== exp_bs && n < SS + 2) begin
            @(negedge clk);
            n++;
        end
        chk("swap_bs", int'(buffer_select), int'(exp_bs));
        chk("swap_ready", int'(cmd_ready), 1);
        vga_vs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    vec_t vecs[9];
    int   lat;

    initial begin
        vecs[0] = '{2'b00, 10, 20, 11, 21, 5, 4, 10, 20, 11, 21};
        vecs[1] = '{2'b00, 318, 238, 400, 300, 3, 4, 318, 238, 319, 239};
        vecs[2] = '{2'b00, 5, 5, 4, 9, 6, 0, 0, 0, 0, 0};
        vecs[3] = '{2'b11, 1, 1, 9, 9, 2, 0, 0, 0, 0, 0};
        vecs[4] = '{2'b00, 320, 0, 330, 5, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{2'b00, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0};
        vecs[6] = '{2'b01, 7, 7, 8, 8, 10, 76800, 0, 0, 319, 239};
        vecs[7] = '{2'b00, 100, 239, 102, 250, 7, 3, 100, 239, 102, 239};
        vecs[8] = '{2'b00, 1023, 1023, 1023, 1023, 9, 0, 0, 0, 0, 0};

        reset = 1'b0; cmd_valid = 1'b0; vga_vs = 1'b1;
        drive(2'b11, 0, 0, 0, 0, 0); cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_we", int'(gpu_we), 0);
        chk("rst_x", int'(gpu_x), 0);
        chk("rst_y", int'(gpu_y), 0);
        chk("rst_data", int'(gpu_data), 0);
        chk("rst_bs", int'(buffer_select), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].c, lat);
            chk("vec_count", wr_q.size(), vecs[i].n);
            cmp_q("vec_model");
            chk("vec_latency", lat, vecs[i].n + 1);
            if (vecs[i].n > 0 && wr_q.size() > 0) begin
                chk("vec_first_x", int'(wr_q[0].x), vecs[i].fx);
                chk("vec_first_y", int'(wr_q[0].y), vecs[i].fy);
                chk("vec_first_d", int'(wr_q[0].d), vecs[i].c);
                chk("vec_last_x", int'(wr_q[$].x), vecs[i].lx);
                chk("vec_last_y", int'(wr_q[$].y), vecs[i].ly);
            end
        end

        for (int i = 0; i < 30; i++) begin
            int x0, y0, x1, y1;
            logic [1:0] op;
            op = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'b11;
            x0 = $urandom_range(0, 330);
            y0 = $urandom_range(0, 250);
            x1 = x0 + $urandom_range(0, 12) - 2;
            y1 = y0 + $urandom_range(0, 6) - 1;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            if (x1 > 1023) x1 = 1023;
            run_cmd(op, x0, y0, x1, y1, $urandom_range(0, 15), lat);
            cmp_q("rand_model");
            chk("rand_latency", lat, exp_q.size() + 1);
        end

        // Back-to-back: cmd_valid stays high across the two fills.
        wr_q.delete(); exp_q.delete();
        model_cmd(2'b00, 50, 60, 52, 60, 4);
        model_cmd(2'b00, 7, 8, 7, 9, 12);
        @(negedge clk);
        drive(2'b00, 50, 60, 52, 60, 4);
        @(posedge clk);
        @(negedge clk);
        drive(2'b00, 7, 8, 7, 9, 12);
        lat = 1;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_gap_cycle", lat, 4);
        chk("b2b_gap_we", int'(gpu_we), 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", lat, 3);
        cmp_q("b2b_model");

        do_swap(1'b1);
        do_swap(1'b0);
        vga_vs = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_vs_ignored", int'(buffer_select), 0);
        vga_vs = 1'b1;
        repeat (4) @(negedge clk);

        do_swap(1'b1);
        wr_q.delete();
        @(negedge clk);
        drive(2'b01, 0, 0, 0, 0, 10);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (wr_q.size() < 100 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("rstmid_we_before", int'(gpu_we), 1);
        reset = 1'b0;
        #1;
        chk("rstmid_we", int'(gpu_we), 0);
        chk("rstmid_bs", int'(buffer_select), 0);
        chk("rstmid_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", int'(cmd_ready), 1);
        run_cmd(2'b00, 30, 40, 33, 41, 9, lat);
        cmp_q("post_rst_model");
        chk("post_rst_latency", lat, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
